// File: rtl/sr2d.sv
// D register built from per-bit SR cores driven by D-to-SR excitation (S=D, R=~D).
// Q and Qb both come from the single stored state, so they are always complementary.
module sr2d #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qb
);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  assign s = D;
  assign r = ~D;

  // S=R=1 cannot come from the excitation, but the core treats it as hold.
  always_comb begin
    q_d = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      unique case ({s[i], r[i]})
        2'b10:   q_d[i] = 1'b1;
        2'b01:   q_d[i] = 1'b0;
        default: q_d[i] = q_q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= RESET_VALUE;
    else     q_q <= q_d;
  end

  assign Q  = q_q;
  assign Qb = ~q_q;

endmodule

// File: tb/tb_sr2d.sv
// Scoreboard bench for sr2d: 1-bit default instance and a 4-bit instance with reset value 1010.
module tb_sr2d;

  typedef struct packed {
    logic       e1;
    logic [3:0] e4;
  } exp_t;

  localparam logic [3:0] RV4 = 4'b1010;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       d1  = 1'b0;
  logic       q1, qb1;
  logic [3:0] d4  = 4'd0;
  logic [3:0] q4, qb4;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  exp_t cur;
  bit   cur_valid = 1'b0;
  bit   drv_done  = 1'b0;

  always #5 clk = ~clk;

  sr2d u_dut1 (
    .clk (clk),
    .rst (rst),
    .D   (d1),
    .Q   (q1),
    .Qb  (qb1)
  );

  sr2d #(.WIDTH(4), .RESET_VALUE(RV4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .D   (d4),
    .Q   (q4),
    .Qb  (qb4)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: after an edge, Q is the reset value if rst was high, else the D held before the edge.
  task automatic step(input logic dv1, input logic [3:0] dv4, input logic rv, input bit glitch);
    exp_t e;
    @(negedge clk);
    rst = rv;
    d1  = glitch ? ~dv1 : dv1;
    d4  = glitch ? ~dv4 : dv4;
    if (glitch) begin
      #2;
      d1 = dv1;
      d4 = dv4;
    end
    e.e1 = rv ? 1'b0 : dv1;
    e.e4 = rv ? RV4  : dv4;
    sb_q.push_back(e);
  endtask

  // Monitor: one expected entry per edge, sampled just after the edge.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      cur_valid = 1'b1;
      check("q1",  {3'b000, q1},  {3'b000, cur.e1});
      check("qb1", {3'b000, qb1}, {3'b000, ~cur.e1});
      check("q4",  q4,  cur.e4);
      check("qb4", qb4, ~cur.e4);
    end
  end

  // Late in each cycle (after any glitch has passed) Q must not have moved since the edge.
  always @(negedge clk) begin
    #4;
    if (cur_valid) begin
      check("hold_q1", {3'b000, q1}, {3'b000, cur.e1});
      check("hold_q4", q4, cur.e4);
    end
  end

  initial begin
    // Reset with D=1: reset wins
    step(1'b1, 4'hF, 1'b1, 1'b0);
    // Capture 1
    step(1'b1, 4'b0110, 1'b0, 1'b0);
    // Toggle pattern 0,1,0,1,1
    step(1'b0, 4'b1001, 1'b0, 1'b0);
    step(1'b1, 4'b0011, 1'b0, 1'b0);
    step(1'b0, 4'b1100, 1'b0, 1'b0);
    step(1'b1, 4'b0101, 1'b0, 1'b0);
    step(1'b1, 4'b0101, 1'b0, 1'b0);
    // Glitch between edges with Q=0
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 1'b1);
    step(1'b0, 4'b1111, 1'b0, 1'b1);
    // Reset mid-operation with Q=1, D=1, then release
    step(1'b1, 4'b0110, 1'b0, 1'b0);
    step(1'b1, 4'b0110, 1'b1, 1'b0);
    step(1'b1, 4'b0110, 1'b0, 1'b0);
    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
    end
    drv_done = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: driver_done=%0d expected 1", drv_done);
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $fatal(1);
  end

endmodule

// File: doc/sr2d.md
Name: sr2d

Overview:
- Positive-edge D flip-flop built as an SR flip-flop core plus D-to-SR excitation logic: S = D, R = ~D.
- Q follows D one clock edge later; Qb is always the complement of Q.
- Used as a single-bit or vector storage element wherever an SR-derived D register is needed.
- Widened through a parameter; each bit has its own independent SR core.

Parameters:
- WIDTH, 1, number of independent bits; D, Q and Qb are all WIDTH bits.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into Q on reset; Qb resets to ~RESET_VALUE.

Ports:
- clk  input  1  clock; all state changes occur on the rising edge.
- rst  input  1  synchronous, active-high reset.
- D  input  WIDTH  data input.
- Q  output  WIDTH  registered true output.
- Qb  output  WIDTH  registered complement output; always equals ~Q.

Behaviour:
- Single clock domain. The only edge is posedge clk. There is no asynchronous path from D or rst to Q or Qb.
- Reset:
  - rst=1 at a rising edge loads Q=RESET_VALUE and Qb=~RESET_VALUE (default: Q=0, Qb=1).
  - rst has priority over D.
  - Reset asserted mid-operation takes effect at the next rising edge and overrides the D value sampled at that edge.
- Before the first reset edge, Q and Qb are unspecified.
- Excitation logic (combinational, per bit): S[i]=D[i], R[i]=~D[i].
- SR core next-state function (per bit), applied at each rising edge with rst=0:
  - S=1, R=0: Q=1.
  - S=0, R=1: Q=0.
  - S=0, R=0: hold.
  - S=1, R=1: forbidden input; the core holds its state. This case cannot arise through the D excitation, but the core must still implement it deterministically.
- Net effect: Q(n+1) = D(n) sampled at the rising edge. Latency is one clock edge.
- Qb is derived from the same stored state, never from a separate register, so Q and Qb can never be equal, even for one delta.
- Sampling semantics:
  - The value of D present before the rising edge is captured.
  - A D change coincident with the edge is not captured until the following edge. This is nonblocking register semantics with no race.
- D changes between edges never alter Q (edge-triggered, not level-sensitive).
- Bits are fully independent; no cross-bit interaction.

Test Plan:
- Reset: clk 10 ns period; D=1, rst=1 for one rising edge -> Q=0, Qb=1 after that edge (default RESET_VALUE).
- Capture 1: rst=0, D=1 held before a rising edge -> Q=1, Qb=0 after the edge; no change before the edge.
- Capture 0 and toggle: drive D=0,1,0,1,1 on successive cycles with each value stable before its edge -> Q=0,1,0,1,1 one edge later. Q holds 1 across the repeated 1, and Qb is the complement at every sample.
- Mid-cycle glitch: with Q=0, pulse D to 1 for 2 ns between edges, then return D to 0 before the edge -> Q stays 0.
- Reset mid-operation: with Q=1, assert rst=1 while D=1 -> Q=0 and Qb=1 at the next edge. Deassert rst -> Q=1 one edge later.
- Vector instance (WIDTH=4, RESET_VALUE=4'b1010): reset -> Q=1010, Qb=0101. Then D=4'b0110 -> Q=0110, Qb=1001 after one edge.
